// File: rtl/term_pkg.sv
// Shared constants for the term scanner: problem size, term indices and FSM encoding.
package term_pkg;

  localparam int N_VARS  = 5;
  localparam int N_TERMS = 6;
  localparam int N_IDX   = 1 << N_VARS;

  // Bit positions of each product term inside an enable mask.
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  localparam logic [N_TERMS-1:0] EN_RESET = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sop_terms.sv
// Combinational sum-of-products: evaluates t1..t6 on a 5-bit vector {X,Y,Z,K,M}
// and ORs together only the terms whose enable bit is set.
module sop_terms
  import term_pkg::*;
(
  input  logic [N_VARS-1:0]  vec,
  input  logic [N_TERMS-1:0] en,
  output logic               f
);

  logic x, y, z, k, m;
  logic [N_TERMS-1:0] term;

  assign {x, y, z, k, m} = vec;

  always_comb begin
    term     = '0;
    term[T1] = y & k & m & ~x;
    term[T2] = ~x & ~y & z & ~m;
    term[T3] = x & ~y & k & ~z;
    term[T4] = ~x & k & ~z;
    term[T5] = ~y & ~k;
    term[T6] = x & ~z & m;
  end

  // An all-zero mask leaves nothing to OR, so F is 0.
  assign f = |(term & en);

endmodule

// File: rtl/term_scanner.sv
// Sweeps all 32 input combinations through the enabled product terms, building a
// truth table and ones count, plus a free-running registered probe of a live vector.
module term_scanner
  import term_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [N_TERMS-1:0]  term_en,
  input  logic [N_VARS-1:0]   probe_vec,
  output logic                busy,
  output logic                done,
  output logic [N_IDX-1:0]    truth_tbl,
  output logic [N_VARS:0]     ones_cnt,
  output logic                probe_f
);

  state_t              state_reg, state_next;
  logic [N_VARS-1:0]   idx_reg;
  logic [N_TERMS-1:0]  latched_en_reg;
  logic [N_IDX-1:0]    truth_tbl_reg;
  logic [N_VARS:0]     ones_cnt_reg;
  logic                probe_f_reg;

  logic                load, step, clear;
  logic                f_scan, f_probe;

  sop_terms u_scan_terms (
    .vec (idx_reg),
    .en  (latched_en_reg),
    .f   (f_scan)
  );

  // The probe path deliberately uses the live mask, not the latched one.
  sop_terms u_probe_terms (
    .vec (probe_vec),
    .en  (term_en),
    .f   (f_probe)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    clear      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          clear      = 1'b1;
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (idx_reg == N_VARS'(N_IDX - 1)) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      latched_en_reg <= EN_RESET;
      truth_tbl_reg  <= '0;
      ones_cnt_reg   <= '0;
      probe_f_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      probe_f_reg <= f_probe;
      if (load) begin
        latched_en_reg <= term_en;
        idx_reg        <= '0;
        truth_tbl_reg  <= '0;
        ones_cnt_reg   <= '0;
      end else if (clear) begin
        idx_reg       <= '0;
        truth_tbl_reg <= '0;
        ones_cnt_reg  <= '0;
      end else if (step) begin
        // idx wraps to 0 after 31; the DONE transition keeps it from being reused.
        truth_tbl_reg[idx_reg] <= f_scan;
        ones_cnt_reg           <= ones_cnt_reg + (N_VARS + 1)'(f_scan);
        idx_reg                <= idx_reg + 1'b1;
      end
    end
  end

  assign busy      = (state_reg == SCAN);
  assign done      = (state_reg == DONE);
  assign truth_tbl = truth_tbl_reg;
  assign ones_cnt  = ones_cnt_reg;
  assign probe_f   = probe_f_reg;

endmodule

// File: tb/tb_term_scanner.sv
// Scoreboard bench for term_scanner: expected sweep results are queued when a sweep
// is started and checked when done is seen; the probe path uses its own queue.
module tb_term_scanner;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [5:0]  term_en;
  logic [4:0]  probe_vec;
  logic        busy, done, probe_f;
  logic [31:0] truth_tbl;
  logic [5:0]  ones_cnt;

  typedef struct packed {
    logic [31:0] tbl;
    logic [5:0]  cnt;
  } exp_t;

  exp_t sb_q[$];
  logic probe_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  term_scanner dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .term_en   (term_en),
    .probe_vec (probe_vec),
    .busy      (busy),
    .done      (done),
    .truth_tbl (truth_tbl),
    .ones_cnt  (ones_cnt),
    .probe_f   (probe_f)
  );

  always #5 clk = ~clk;

  function automatic logic model_f(input logic [4:0] v, input logic [5:0] en);
    logic X, Y, Z, K, M;
    {X, Y, Z, K, M} = v;
    return (en[0] & Y & K & M & ~X) | (en[1] & ~X & ~Y & Z & ~M) |
           (en[2] & X & ~Y & K & ~Z) | (en[3] & ~X & K & ~Z) |
           (en[4] & ~Y & ~K) | (en[5] & X & ~Z & M);
  endfunction

  function automatic exp_t model_sweep(input logic [5:0] en);
    exp_t e;
    e.tbl = '0;
    e.cnt = '0;
    for (int i = 0; i < 32; i++) begin
      e.tbl[i] = model_f(5'(i), en);
      e.cnt    = e.cnt + 6'(e.tbl[i]);
    end
    return e;
  endfunction

  // Leaves the bench at the falling edge just after the start edge.
  task automatic drive_start(input logic [5:0] en, input bit will_cancel);
    exp_t z;
    z = '0;
    @(negedge clk);
    term_en = en;
    start   = 1'b1;
    sb_q.push_back(will_cancel ? z : model_sweep(en));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic get_exp(output exp_t e);
    if (sb_q.size() == 0) e = 'x;
    else e = sb_q.pop_front();
  endtask

  // done_edge is the edge after the start edge at which done is sampled high.
  task automatic wait_done(output int done_edge, output int busy_cycles, output bit seen);
    int edges;
    edges = 0;
    busy_cycles = 0;
    seen = 1'b0;
    done_edge = 0;
    if (busy) busy_cycles++;
    while (!seen && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1'b1;
        done_edge = edges + 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; term_en = 6'h3F; probe_vec = 5'b00010;
    #1;
    n_tests++;
    if ({busy, done, probe_f} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: {busy,done,probe_f}=%b want 000", {busy, done, probe_f});
    end
    n_tests++;
    if (truth_tbl !== 32'h0 || ones_cnt !== 6'd0) begin
      n_fail++; $display("FAIL reset_data: tbl=%h cnt=%0d want 0/0", truth_tbl, ones_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_sweep(input string name, input logic [5:0] en,
                            input logic [31:0] want_tbl, input logic [5:0] want_cnt);
    exp_t e; int de, bc; bit seen;
    drive_start(en, 1'b0);
    wait_done(de, bc, seen);
    get_exp(e);
    $display("[TB] sweep %s en=%h tbl=%h cnt=%0d edge=%0d busy=%0d", name, en, truth_tbl, ones_cnt, de, bc);
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL %s_done: no done within 100 edges", name); end
    n_tests++;
    if (de !== 33) begin n_fail++; $display("FAIL %s_latency: done edge=%0d want 33", name, de); end
    n_tests++;
    if (bc !== 32) begin n_fail++; $display("FAIL %s_busy: busy cycles=%0d want 32", name, bc); end
    n_tests++;
    if (truth_tbl !== e.tbl || truth_tbl !== want_tbl) begin
      n_fail++; $display("FAIL %s_tbl: got %h want %h", name, truth_tbl, want_tbl);
    end
    n_tests++;
    if (ones_cnt !== e.cnt || ones_cnt !== want_cnt) begin
      n_fail++; $display("FAIL %s_cnt: got %0d want %0d", name, ones_cnt, want_cnt);
    end
    // done pulse lasts one cycle; results then hold while term_en wanders.
    start   = 1'b1;
    term_en = ~en;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL %s_after_done: {busy,done}=%b want 00", name, {busy, done});
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (truth_tbl !== want_tbl || ones_cnt !== want_cnt || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_hold: tbl=%h cnt=%0d busy=%b want %h/%0d/0", name, truth_tbl, ones_cnt, busy, want_tbl, want_cnt);
    end
  endtask

  task automatic test_abort();
    exp_t e, full; int done_seen; logic [5:0] prefix;
    full = model_sweep(6'h3F);
    drive_start(6'h3F, 1'b1);
    repeat (9) @(negedge clk);
    prefix = '0;
    for (int i = 0; i < 9; i++) prefix = prefix + 6'(full.tbl[i]);
    n_tests++;
    if (ones_cnt !== prefix || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_midway: cnt=%0d busy=%b want %0d/1", ones_cnt, busy, prefix);
    end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    get_exp(e);
    $display("[TB] abort at scan cycle 10 tbl=%h cnt=%0d busy=%b", truth_tbl, ones_cnt, busy);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b done=%b want 0/0", busy, done);
    end
    n_tests++;
    if (truth_tbl !== e.tbl || ones_cnt !== e.cnt) begin
      n_fail++; $display("FAIL abort_clear: tbl=%h cnt=%0d want %h/%0d", truth_tbl, ones_cnt, e.tbl, e.cnt);
    end
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    n_tests++;
    if (done_seen !== 0) begin
      n_fail++; $display("FAIL abort_no_done: active cycles=%0d want 0", done_seen);
    end
  endtask

  task automatic test_disturbed();
    exp_t e; int de, bc; bit seen;
    drive_start(6'h3F, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1; term_en = 6'h10;
    @(negedge clk);
    start = 1'b0; term_en = 6'h08;
    wait_done(de, bc, seen);
    get_exp(e);
    $display("[TB] disturbed sweep tbl=%h cnt=%0d", truth_tbl, ones_cnt);
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL disturbed_done: no done within 100 edges"); end
    n_tests++;
    if (de + 6 !== 33 || bc + 6 !== 32) begin
      n_fail++; $display("FAIL disturbed_timing: edge=%0d busy=%0d want %0d/%0d", de + 6, bc + 6, 33, 32);
    end
    n_tests++;
    if (truth_tbl !== e.tbl || ones_cnt !== 6'd18) begin
      n_fail++; $display("FAIL disturbed_result: tbl=%h cnt=%0d want %h/18", truth_tbl, ones_cnt, e.tbl);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid_scan();
    exp_t e;
    drive_start(6'h3F, 1'b1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    get_exp(e);
    $display("[TB] rst mid-scan tbl=%h cnt=%0d busy=%b", truth_tbl, ones_cnt, busy);
    n_tests++;
    if (truth_tbl !== e.tbl || ones_cnt !== e.cnt || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: tbl=%h cnt=%0d busy=%b done=%b want 0", truth_tbl, ones_cnt, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    test_sweep("post_rst", 6'h10, 32'h00330033, 6'd8);
  endtask

  task automatic test_probe();
    logic want;
    @(negedge clk);
    term_en = 6'h3F; probe_vec = 5'b00010;
    probe_q.push_back(1'b1);
    @(negedge clk);
    want = probe_q.pop_front();
    $display("[TB] probe vec=00010 en=3F f=%b", probe_f);
    n_tests++;
    if (probe_f !== want) begin n_fail++; $display("FAIL probe_basic: got %b want %b", probe_f, want); end
    for (int i = 0; i < 32; i++) begin
      term_en   = 6'($urandom_range(0, 63));
      probe_vec = 5'(i);
      probe_q.push_back(model_f(probe_vec, term_en));
      @(negedge clk);
      want = probe_q.pop_front();
      $display("[TB] probe vec=%b en=%h f=%b", probe_vec, term_en, probe_f);
      n_tests++;
      if (probe_f !== want) begin
        n_fail++; $display("FAIL probe_vec%0d: got %b want %b", i, probe_f, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    test_sweep("b2b_t1", 6'h01, model_sweep(6'h01).tbl, model_sweep(6'h01).cnt);
    test_sweep("b2b_t6", 6'h20, model_sweep(6'h20).tbl, model_sweep(6'h20).cnt);
  endtask

  initial begin
    test_reset();
    test_sweep("all_terms", 6'h3F, model_sweep(6'h3F).tbl, 6'd18);
    test_sweep("t5_only", 6'h10, 32'h00330033, 6'd8);
    test_sweep("t4_only", 6'h08, 32'h00000C0C, 6'd4);
    test_sweep("no_terms", 6'h00, 32'h00000000, 6'd0);
    test_abort();
    test_disturbed();
    test_rst_mid_scan();
    test_probe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/term_scanner.md
TERM_SCANNER -- requirements
Module: term_scanner

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: start  in  1  one-cycle request to begin a sweep.
REQ-004 SHALL have ports: abort  in  1  cancel a sweep in progress.
REQ-005 SHALL have ports: term_en  in  6  enable mask for product terms t1..t6, bit0 = t1.
REQ-006 SHALL have ports: probe_vec  in  5  live vector {X,Y,Z,K,M}, X is the MSB.
REQ-007 SHALL have ports: busy  out  1  high while sweeping.
REQ-008 SHALL have ports: done  out  1  one-cycle pulse at sweep end.
REQ-009 SHALL have ports: truth_tbl  out  32  bit i = F(idx=i).
REQ-010 SHALL have ports: ones_cnt  out  6  number of idx with F = 1.
REQ-011 SHALL have ports: probe_f  out  1  registered F(probe_vec).
REQ-012 SHALL have no parameters: N_VARS = 5 and N_TERMS = 6 are fixed constants.

Function
REQ-013 SHALL define the product terms as follows, with ~ denoting inversion:
- t1 = Y&K&M&~X
- t2 = ~X&~Y&Z&~M
- t3 = X&~Y&K&~Z
- t4 = ~X&K&~Z
- t5 = ~Y&~K
- t6 = X&~Z&M
REQ-014 SHALL compute F = OR over j of (tj AND latched_en[j]); F = 0 when the mask is all zero.
REQ-015 SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-016 SHALL, in IDLE with start=1, on that edge: latch term_en, set idx=0, clear truth_tbl and ones_cnt, enter SCAN.
REQ-017 SHALL, on each SCAN cycle: write truth_tbl[idx]=F(idx); ones_cnt += F; idx += 1.
REQ-018 SHALL leave SCAN for DONE after processing idx=31; the 5-bit idx wraps to 0 and is not reused.
REQ-019 SHALL assert done for exactly the single DONE cycle, then return to IDLE.
REQ-020 SHALL produce exactly 32 SCAN cycles, so done is high on the 33rd edge after the start edge.
REQ-021 SHALL hold busy = 1 in SCAN and busy = 0 in IDLE and DONE.
REQ-022 SHALL ignore start while in SCAN or DONE; no restart and no re-latch of term_en.
REQ-023 SHALL, on abort=1 in SCAN: go to IDLE next edge, clear truth_tbl and ones_cnt to 0, no done pulse.
REQ-024 SHALL ignore abort in IDLE and DONE.
REQ-025 SHALL give abort priority over start when both are high.
REQ-026 SHALL ignore changes to term_en during SCAN; the latched copy is used.
REQ-027 SHALL hold truth_tbl and ones_cnt stable from done until the next accepted start or abort.
REQ-028 SHALL make ones_cnt 6 bits wide, range 0..32, with no overflow possible.
REQ-029 SHALL register probe_f = F(probe_vec) using the current term_en (not the latched copy), 1-cycle latency, every cycle in all states.

Reset
REQ-030 SHALL, on rst=1, asynchronously force: state=IDLE, idx=0, latched_en=6'b111111, truth_tbl=0, ones_cnt=0, busy=0, done=0, probe_f=0.
REQ-031 SHALL, on rst mid-SCAN, abandon the sweep with no done pulse; the first start after rst release begins a fresh sweep.

Structure
REQ-032 SHALL place N_VARS, N_TERMS, the state encoding (IDLE/SCAN/DONE) and term index constants T1..T6 in shared package term_pkg.
REQ-033 SHALL put term evaluation (REQ-013/014) in combinational sub-module sop_terms (vec[4:0], en[6] -> f).
REQ-034 SHALL instantiate sop_terms twice: once for the sweep index, once for the probe path.
REQ-035 SHALL keep all sequential logic in term_scanner.

Verification
REQ-036 SHALL cover: all terms, term_en=6'h3F, start -> done 33 edges later, ones_cnt=18, busy high exactly 32 cycles.
REQ-037 SHALL cover: t5 only, term_en=6'h10 -> truth_tbl=32'h00330033, ones_cnt=8.
REQ-038 SHALL cover: t4 only, term_en=6'h08 -> truth_tbl=32'h00000C0C, ones_cnt=4; then term_en=0 and restart -> truth_tbl=0, ones_cnt=0.
REQ-039 SHALL cover: abort at SCAN cycle 10 -> IDLE next edge, no done pulse, truth_tbl=0, ones_cnt=0.
REQ-040 SHALL cover: start pulsed mid-SCAN and term_en changed mid-SCAN -> results identical to an undisturbed run with ones_cnt=18.
REQ-041 SHALL cover: rst asserted mid-SCAN -> outputs zero immediately without waiting for a clock edge.
REQ-042 SHALL cover: probe_vec=5'b00010 with term_en=6'h3F -> probe_f=1 one edge later.
